// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, PC select encoding and fetch states
package core_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
  localparam logic [1:0] PCSEL_REL   = 2'b01;
  localparam logic [1:0] PCSEL_JALR  = 2'b10;
  localparam logic [1:0] PCSEL_RESET = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_EXEC     = 3'd3,
    ST_HALT     = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended immediate extraction by instruction format
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [6:0]  opcode,
  output logic [31:0] imm
);

  // Select the immediate layout implied by the opcode; unknown opcodes give 0
  always_comb begin
    imm = 32'h0;
    case (opcode)
      OP_ITYPE, OP_LOAD, OP_JALR: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BTYPE:                   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:                     imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_LUI, OP_AUIPC:           imm = {ir[31:12], 12'h000};
      default:                    imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, instruction fetch sequencer and decoder
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16,
  parameter int          TO_W         = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enPC,
  input  logic        PCsel1,
  input  logic        PCsel0,
  input  logic        done,
  input  logic [31:0] alu_result,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        start,
  output logic [6:0]  opcode,
  output logic [2:0]  lorbtype,
  output logic [3:0]  alu_action,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] pc,
  output logic [31:0] ir_pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic         ir_valid_q, ir_valid_d;
  logic         fault_q, fault_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  imem_addr_q, imem_addr_d;
  logic         start_q, start_d;

  logic [31:0]  imm_raw;
  logic [31:0]  target;
  logic [1:0]   pcsel;
  logic         pc_upd;
  logic         misaligned;

  imm_gen u_imm_gen (
    .ir     (ir_q),
    .opcode (ir_q[6:0]),
    .imm    (imm_raw)
  );

  assign pcsel = {PCsel1, PCsel0};

  // Branch/jump target; always relative to the held instruction so a held enPC is idempotent
  always_comb begin
    target = ir_pc_q + 32'd4;
    case (pcsel)
      PCSEL_PLUS4: target = ir_pc_q + 32'd4;
      PCSEL_REL:   target = ir_pc_q + imm_raw;
      PCSEL_JALR:  target = alu_result & ~32'h1;
      PCSEL_RESET: target = RESET_VECTOR;
      default:     target = ir_pc_q + 32'd4;
    endcase
  end

  assign pc_upd     = enPC && (state_q != ST_HALT);
  assign misaligned = pc_upd && (target[1:0] != 2'b00);

  // Next-state logic: PC update first, then sequencing, then the misalignment override
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    start_d     = 1'b0;

    if (pc_upd && !misaligned) begin
      pc_d = target;
    end

    case (state_q)
      // Straight out of reset the strobe is still low, so raise it here first
      ST_FETCH: begin
        if (imem_req_q) begin
          state_d = ST_WAIT_MEM;
          cnt_d   = '0;
        end else begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_d;
        end
      end
      // ir_pc takes the address the word was actually requested from
      ST_WAIT_MEM: begin
        if (imem_valid) begin
          ir_d       = imem_rdata;
          ir_pc_d    = imem_addr_q;
          ir_valid_d = 1'b1;
          start_d    = 1'b1;
          state_d    = ST_ISSUE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_EXEC;
      end
      // Retire: the fetch request goes out from the already-updated pc
      ST_EXEC: begin
        if (done) begin
          ir_valid_d  = 1'b0;
          state_d     = ST_FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_d;
        end
      end
      ST_HALT: begin
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (misaligned) begin
      fault_d    = 1'b1;
      state_d    = ST_HALT;
      ir_valid_d = 1'b0;
      imem_req_d = 1'b0;
      start_d    = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_VECTOR;
      ir_q        <= 32'h0;
      ir_pc_q     <= RESET_VECTOR;
      ir_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_VECTOR;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      start_q     <= start_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign start      = start_q;
  assign pc         = pc_q;
  assign ir_pc      = ir_pc_q;
  assign pc_plus4   = ir_pc_q + 32'd4;
  assign fault      = fault_q;

  assign opcode     = ir_valid_q ? ir_q[6:0]            : 7'h0;
  assign lorbtype   = ir_valid_q ? ir_q[14:12]          : 3'h0;
  assign alu_action = ir_valid_q ? {ir_q[30], ir_q[14:12]} : 4'h0;
  assign rs1        = ir_valid_q ? ir_q[19:15]          : 5'h0;
  assign rs2        = ir_valid_q ? ir_q[24:20]          : 5'h0;
  assign rd         = ir_valid_q ? ir_q[11:7]           : 5'h0;
  assign imm        = ir_valid_q ? imm_raw              : 32'h0;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the multi-cycle RV32I core. Owns the PC and fetches one instruction per controller cycle over a req/valid instruction-memory interface, then decodes it into the fields the instruction controller consumes (opcode, lorbtype, alu_action, immediate). It applies the controller's PC-update commands (enPC, PCsel1/PCsel0) and sequences the next fetch on done. The opcode output is forced to zero while no instruction is held, which is how the controller knows when to wait.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset and on PCsel=11
TIMEOUT, 16, maximum cycles in WAIT_MEM before fault
TO_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
enPC  in  1  controller: apply PC update this cycle
PCsel1  in  1  controller: PC select, MSB
PCsel0  in  1  controller: PC select, LSB
done  in  1  controller: current instruction retired
alu_result  in  32  datapath ALU output, used as the jalr target
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  32  fetch address, word aligned
imem_rdata  in  32  instruction word
imem_valid  in  1  imem_rdata valid, one-cycle pulse
start  out  1  one-cycle pulse when a new instruction is first presented
opcode  out  7  IR[6:0] when ir_valid, else 0
lorbtype  out  3  IR[14:12] (funct3)
alu_action  out  4  {IR[30], IR[14:12]}
rs1, rs2, rd  out  5 each  register fields
imm  out  32  sign-extended immediate for the opcode's format
pc  out  32  PC register
ir_pc  out  32  address of the held instruction
pc_plus4  out  32  ir_pc + 4, link value
fault  out  1  sticky: misaligned target or fetch timeout

Behaviour:
- Reset (synchronous, rst_n=0 at a rising edge):
  - pc=RESET_VECTOR, ir=0, ir_pc=RESET_VECTOR, ir_valid=0, fault=0, timeout count=0, state=FETCH.
  - All strobes (imem_req, start) are 0.
  - Reset mid-operation aborts the transaction in flight. Late imem_valid pulses are ignored.
- State machine:
  - FETCH: imem_req=1, imem_addr=pc for exactly 1 cycle; go to WAIT_MEM and clear the count.
  - WAIT_MEM: count each cycle.
    - imem_valid=1: ir<=imem_rdata, ir_pc<=pc, ir_valid<=1; go to ISSUE.
    - Count reaches TIMEOUT-1 without valid: fault<=1; go to HALT.
  - ISSUE: start=1 for 1 cycle; go to EXEC.
  - EXEC: hold the IR.
    - done=1: ir_valid<=0; go to FETCH next cycle, which fetches from the already-updated pc.
  - HALT: terminal. ir_valid=0, imem_req=0. Only reset exits.
- imem_valid is ignored in every state except WAIT_MEM.
- PC update (any state except HALT): when enPC=1 at an edge, pc<=target, selected by {PCsel1,PCsel0}:
  - 00: ir_pc+4
  - 01: ir_pc+imm (B-imm for branch opcode, J-imm for jal)
  - 10: alu_result & ~32'h1 (jalr)
  - 11: RESET_VECTOR
- Targets derive from ir_pc, never pc, so enPC held for several cycles is idempotent.
- If target[1:0]!=00, pc is not written; fault<=1; go to HALT.
- Decode outputs (opcode, lorbtype, alu_action, rs*, rd, imm) are combinational from ir, gated to 0 when ir_valid=0.
- imm format by opcode:
  - I for 0010011, 0000011, 1100111
  - S for 0100011
  - B for 1100011
  - J for 1101111
  - U (IR[31:12]<<12) for 0110111, 0010111
  - 0 otherwise
- Arithmetic is 32-bit modulo; wrap at 0xFFFF_FFFC is legal.
- enPC and done in the same cycle: the PC update and the EXEC→FETCH transition both take effect.
- done outside EXEC is ignored.

Decomposition:
- Shared package core_pkg:
  - opcode constants (rtype … btype)
  - PCsel encoding constants
  - fetch-state enum
- One sub-module, imm_gen: combinational, ir + opcode → 32-bit imm.
- Reuse core_pkg opcodes in the controller.

Test Plan:
- Reset with RESET_VECTOR=0x100 → pc=0x100, one imem_req pulse with imem_addr=0x100, opcode=0 until valid.
- Return 0x00500093 (addi x1,x0,5) after 3 cycles → opcode=0010011, alu_action=0000, rd=1, imm=5, start pulse one cycle after valid.
- Hold branch 0xFE000CE3 at ir_pc=0x200; enPC=1 with PCsel=01 for 2 cycles → pc=0x1F8 (imm=-8); done → next fetch addr 0x1F8.
- jalr held, alu_result=0x301, enPC with PCsel=10 → pc=0x300. Then alu_result=0x302 → fault=1, pc unchanged, no further imem_req.
- No imem_valid for TIMEOUT cycles → fault=1 on cycle TIMEOUT. A later imem_valid is ignored, opcode stays 0.
- rst_n=0 during WAIT_MEM, imem_valid arrives one cycle after reset release → ignored; fresh imem_req at RESET_VECTOR.
